seq_counter_nbit: RTL and testbench

SEQ_COUNTER_NBIT -- requirements
Module: seq_counter_nbit

---
 rtl/seq_counter_nbit.sv | 108 ++++++++++
 tb/tb_seq_counter_nbit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_counter_nbit.sv
// Up/down counter with clear, load, wrap/one-shot modes and a terminal-count pulse on a 28-bit I/O bus.
// Optional prescaler: define SEQ_CTR_PRESCALE_EN so that a step is taken every PRESCALE enabled cycles.
module seq_counter_nbit #(
   parameter int WIDTH    = 16,
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [27:0] io_in,
   output logic [27:0] io_out,
   output logic [27:0] io_oeb
);

   typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] next_val;
   logic [WIDTH-1:0] terminal;
   logic             tc;
   logic             done;
   logic             step;

   logic             en;
   logic             dir;
   logic             clr;
   logic             load;
   logic             mode;
   logic [WIDTH-1:0] load_val;
   logic             unused_in;

   assign en        = io_in[0];
   assign dir       = io_in[1];
   assign clr       = io_in[2];
   assign load      = io_in[3];
   assign mode      = io_in[4];
   assign load_val  = io_in[5 +: WIDTH];
   assign unused_in = ^io_in;

   assign next_val = dir ? count + WIDTH'(1) : count - WIDTH'(1);
   assign terminal = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

`ifdef SEQ_CTR_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre;
   logic          pre_hit;

   assign pre_hit = (pre == PW'(PRESCALE - 1));
   assign step    = en & ~clr & ~load & pre_hit;

   // Prescaler freezes while stopped so a restart via clr/load begins a fresh period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (en) begin
         if (clr || load)
            pre <= '0;
         else if (state == RUN)
            pre <= pre_hit ? '0 : pre + PW'(1);
      end
   end
`else
   assign step = en & ~clr & ~load;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         state <= RUN;
         tc    <= 1'b0;
         done  <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (en) begin
            if (clr) begin
               count <= '0;
               state <= RUN;
               done  <= 1'b0;
            end else if (load) begin
               count <= load_val;
               state <= RUN;
               done  <= 1'b0;
            end else if (step && state == RUN) begin
               count <= next_val;
               // Wrap mode flags leaving terminal; one-shot flags arriving at it.
               if (!mode) begin
                  tc <= (count == terminal);
               end else if (next_val == terminal) begin
                  state <= STOP;
                  done  <= 1'b1;
                  tc    <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      io_out              = '0;
      io_out[WIDTH-1:0]   = count;
      io_out[27]          = tc;
      io_out[26]          = done;
   end

   assign io_oeb = 28'hFFFFFFF;

endmodule

// File: tb/tb_seq_counter_nbit.sv
// Bench for seq_counter_nbit (WIDTH=8): directed scenarios plus randomized traffic checked
// against an arithmetic reference model; handles builds with or without SEQ_CTR_PRESCALE_EN.
module tb_seq_counter_nbit;

   localparam int WIDTH    = 8;
   localparam int PRESCALE = 4;
   localparam int MAXV     = (1 << WIDTH) - 1;

   logic        clk;
   logic        rst_n;
   logic [27:0] io_in;
   logic [27:0] io_out;
   logic [27:0] io_oeb;

   int n_tests;
   int n_fail;

   // reference model state
   int m_cnt;
   int m_pre;
   bit m_stop;
   bit m_done;
   bit m_tc;

   seq_counter_nbit #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_in (io_in),
      .io_out(io_out),
      .io_oeb(io_oeb)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt  = 0;
      m_pre  = 0;
      m_stop = 0;
      m_done = 0;
      m_tc   = 0;
   endfunction

   function automatic logic [27:0] model_out();
      logic [27:0] e;
      e        = '0;
      e[7:0]   = m_cnt[7:0];
      e[27]    = m_tc;
      e[26]    = m_done;
      return e;
   endfunction

   function automatic void model_clock(bit en, bit dir, bit clr, bit load, bit mode, int data);
      bit fire;
      int term;
      int nxt;
      m_tc = 0;
      if (!en) return;
      if (clr || load) begin
         m_cnt  = clr ? 0 : data;
         m_pre  = 0;
         m_stop = 0;
         m_done = 0;
         return;
      end
      if (m_stop) return;
`ifdef SEQ_CTR_PRESCALE_EN
      fire  = (m_pre == PRESCALE - 1);
      m_pre = (m_pre + 1) % PRESCALE;
`else
      fire = 1;
`endif
      if (!fire) return;
      term = dir ? MAXV : 0;
      nxt  = dir ? (m_cnt + 1) % (MAXV + 1) : (m_cnt + MAXV) % (MAXV + 1);
      if (!mode) begin
         m_tc = (m_cnt == term);
      end else if (nxt == term) begin
         m_stop = 1;
         m_done = 1;
         m_tc   = 1;
      end
      m_cnt = nxt;
   endfunction

   // driver: apply inputs, clock once, advance model, compare just after the edge
   task automatic drive(input string tag, input bit en, input bit dir, input bit clr,
                        input bit load, input bit mode, input int data);
      logic [27:0] v;
      v         = 28'($urandom) & 28'hFFE0000;  // noise on ignored upper bits
      v[0]      = en;
      v[1]      = dir;
      v[2]      = clr;
      v[3]      = load;
      v[4]      = mode;
      v[12:5]   = data[7:0];
      io_in     = v;
      @(posedge clk);
      model_clock(en, dir, clr, load, mode, data);
      #1;
      check(tag, io_out, model_out());
   endtask

   // async reset asserted mid-cycle, checked before the next edge
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check(tag, io_out, 28'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      io_in   = '0;
      rst_n   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", io_out, 28'h0);
      check("oeb", io_oeb, 28'hFFFFFFF);
      @(negedge clk);
      rst_n = 1'b1;

      // first edge after reset release with en=0: nothing moves
      drive("post_rst_idle", 0, 1, 0, 0, 0, 8'h77);

      // scenario: wrap up from FE
      drive("wrap_load", 1, 1, 0, 1, 0, 8'hFE);
      for (int i = 0; i < 3; i++) drive("wrap_step", 1, 1, 0, 0, 0, 0);
      drive("wrap_idle", 0, 1, 0, 0, 0, 0);

      // scenario: one-shot down from 03
      drive("os_load", 1, 0, 0, 1, 1, 8'h03);
      for (int i = 0; i < 14; i++) drive("os_step", 1, 0, 0, 0, 1, 0);
      drive("os_mode_flip", 1, 1, 0, 0, 0, 0);

      // scenario: priority clr over load, and en=0 blocks both
      drive("pri_load", 1, 1, 0, 1, 0, 8'h3C);
      drive("pri_en0", 0, 1, 1, 1, 0, 8'h55);
      drive("pri_en1", 1, 1, 1, 1, 0, 8'h55);

      // scenario: prescale timing with an en=0 gap mid-way
      drive("ps_clr", 1, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive("ps_a", 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive("ps_gap", 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive("ps_b", 1, 1, 0, 0, 0, 0);

      // scenario: stop at FF then restart via load
      drive("rs_load", 1, 1, 0, 1, 1, 8'hFD);
      for (int i = 0; i < 14; i++) drive("rs_run", 1, 1, 0, 0, 1, 0);
      drive("rs_reload", 1, 1, 0, 1, 1, 8'h10);
      for (int i = 0; i < 4; i++) drive("rs_resume", 1, 1, 0, 0, 1, 0);

      // scenario: async reset mid-count
      drive("ar_load", 1, 1, 0, 1, 0, 8'h34);
      drive("ar_step", 1, 1, 0, 0, 0, 0);
      async_reset("async_rst");
      drive("ar_after", 0, 1, 0, 0, 0, 0);
      drive("ar_count", 1, 1, 0, 0, 0, 0);

      // randomized traffic
      begin
         bit r_mode;
         bit r_dir;
         r_mode = 0;
         r_dir  = 1;
         for (int i = 0; i < 3000; i++) begin
            int data;
            int pick;
            if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 29) == 0) r_dir  = ~r_dir;
            pick = $urandom_range(0, 3);
            data = (pick == 0) ? 0 : (pick == 1) ? MAXV : $urandom_range(0, MAXV);
            if ($urandom_range(0, 199) == 0) begin
               async_reset("rand_rst");
            end else begin
               drive("rand", $urandom_range(0, 9) < 8, r_dir,
                     $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                     r_mode, data);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
